// File: rtl/scanner_xfer_receiver.sv
// Receiver for the scanner buffer-transfer link. It accepts one valid/ready burst
// into a show-ahead FIFO, drains it downstream, and reports state, count and errors.
module scanner_xfer_receiver #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     xfer,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [1:0]               state,
  output logic [CNT_W-1:0]         words_rcvd,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     done,
  output logic                     err_flag
);

  // state | meaning
  // IDLE  | waiting for xfer
  // RECV  | accepting burst words until in_last
  // DRAIN | burst complete, waiting for the FIFO to empty
  // DONE  | one-cycle end-of-burst marker
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  // Full blocks ingress even when a pop lands in the same cycle.
  assign in_ready  = (state == S_RECV) && (fifo_count < FULL);
  assign push      = in_valid && in_ready;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      words_rcvd <= '0;
      err_flag   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (state == S_IDLE && xfer) begin
        words_rcvd <= '0;
      end else if (push && words_rcvd != CNT_MAX) begin
        words_rcvd <= words_rcvd + 1'b1;
      end

      // Starting a burst wins over a stray word seen in the same IDLE cycle.
      if (state == S_IDLE && xfer) begin
        err_flag <= 1'b0;
      end else if (in_valid && state != S_RECV) begin
        err_flag <= 1'b1;
      end

      case (state)
        S_IDLE:  if (xfer) state <= S_RECV;
        S_RECV:  if (push && in_last) state <= S_DRAIN;
        S_DRAIN: if (fifo_count == '0) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scanner_xfer_receiver.sv
// Directed bench for scanner_xfer_receiver; a scoreboard queue holds accepted words
// and is checked against both a default instance and a CNT_W=4 instance.
module tb_scanner_xfer_receiver;

  logic       clk = 1'b0;
  logic       reset, xfer, in_valid, in_last, out_ready;
  logic [7:0] in_data;

  logic       in_ready, out_valid, done, err_flag;
  logic [7:0] out_data;
  logic [1:0] state;
  logic [7:0] words_rcvd;
  logic [4:0] fifo_count;

  logic       in_ready4, out_valid4, done4, err_flag4;
  logic [7:0] out_data4;
  logic [1:0] state4;
  logic [3:0] words_rcvd4;
  logic [4:0] fifo_count4;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  scanner_xfer_receiver #(.DATA_W(8), .DEPTH(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .xfer(xfer), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .state(state), .words_rcvd(words_rcvd),
    .fifo_count(fifo_count), .done(done), .err_flag(err_flag)
  );

  scanner_xfer_receiver #(.DATA_W(8), .DEPTH(16), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .xfer(xfer), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4),
    .out_ready(out_ready), .state(state4), .words_rcvd(words_rcvd4),
    .fifo_count(fifo_count4), .done(done4), .err_flag(err_flag4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(d);
        ok = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_state(input logic [1:0] s);
    int t = 0;
    while (state !== s && t < 100) begin
      tick();
      t++;
    end
    check("wait_state", 32'(state), 32'(s));
  endtask

  // Scoreboard egress: a pop happens at the next rising edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("pop_unexpected", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = q.pop_front();
        check("out_data", 32'(out_data), 32'(e));
        check("out_data_cnt4", 32'(out_data4), 32'(e));
      end
    end
  end

  initial begin
    reset = 1'b1; xfer = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = 8'h00; out_ready = 1'b0;

    // reset
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_words", 32'(words_rcvd), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_flag), 32'd0);
    reset = 1'b0;
    tick();

    // basic burst
    out_ready = 1'b1;
    xfer = 1'b1;
    tick();
    xfer = 1'b0;
    check("b_state_recv", 32'(state), 32'd1);
    check("b_in_ready", 32'(in_ready), 32'd1);
    check("b_words0", 32'(words_rcvd), 32'd0);
    for (int i = 0; i < 5; i++) send_word(8'h11 + 8'(i), i == 4);
    check("b_state_drain", 32'(state), 32'd2);
    wait_state(2'd3);
    check("b_done", 32'(done), 32'd1);
    check("b_fifo_empty", 32'(fifo_count), 32'd0);
    tick();
    check("b_state_idle", 32'(state), 32'd0);
    check("b_done_low", 32'(done), 32'd0);
    check("b_words", 32'(words_rcvd), 32'd5);
    check("b_done_cycles", 32'(done_cnt), 32'd1);
    check("b_sb_empty", 32'(q.size()), 32'd0);

    // backpressure, plus saturation on the CNT_W=4 instance
    out_ready = 1'b0;
    xfer = 1'b1;
    tick();
    xfer = 1'b0;
    for (int i = 0; i < 16; i++) send_word(8'h40 + 8'(i), 1'b0);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    check("bp_fifo_full", 32'(fifo_count), 32'd16);
    check("bp_fifo_full4", 32'(fifo_count4), 32'd16);
    check("bp_words16", 32'(words_rcvd), 32'd16);
    check("bp_words_sat", 32'(words_rcvd4), 32'd15);
    in_valid = 1'b1; in_data = 8'h50; in_last = 1'b0;
    tick(); tick();
    check("bp_held", 32'(fifo_count), 32'd16);
    check("bp_held_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_word(8'h50 + 8'(i), i == 3);
    wait_state(2'd3);
    check("bp_words20", 32'(words_rcvd), 32'd20);
    check("bp_words_sat20", 32'(words_rcvd4), 32'd15);
    check("bp_sb_empty", 32'(q.size()), 32'd0);
    tick();
    check("bp_idle", 32'(state), 32'd0);

    // stray traffic in IDLE
    in_valid = 1'b1; in_data = 8'hEE;
    tick();
    in_valid = 1'b0;
    check("s_err_set", 32'(err_flag), 32'd1);
    check("s_fifo_zero", 32'(fifo_count), 32'd0);
    tick();
    check("s_err_sticky", 32'(err_flag), 32'd1);
    xfer = 1'b1;
    tick();
    xfer = 1'b0;
    check("s_err_clear", 32'(err_flag), 32'd0);
    check("s_state_recv", 32'(state), 32'd1);

    // reset mid-burst
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_word(8'h60 + 8'(i), 1'b0);
    check("r_fifo7", 32'(fifo_count), 32'd7);
    check("r_words7", 32'(words_rcvd), 32'd7);
    reset = 1'b1;
    tick();
    check("r_state", 32'(state), 32'd0);
    check("r_fifo", 32'(fifo_count), 32'd0);
    check("r_words", 32'(words_rcvd), 32'd0);
    check("r_out_valid", 32'(out_valid), 32'd0);
    check("r_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    q.delete();
    tick();
    check("r_stays_idle", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
